// File: rtl/regfile_write_arbiter_if.sv
// Write-request bus between the two writeback sources and the register-file write arbiter.
interface regfile_write_arbiter_if;
  logic        in_Hold;
  logic        in_ValidA;
  logic [3:0]  in_AddrA;
  logic [15:0] in_DataA;
  logic        out_ReadyA;
  logic        in_ValidB;
  logic [3:0]  in_AddrB;
  logic [15:0] in_DataB;
  logic        out_ReadyB;
  logic [3:0]  in_ReadReg1;
  logic [3:0]  in_ReadReg2;
  logic        out_RegWrite;
  logic [3:0]  out_WriteAddr;
  logic [15:0] out_Data;
  logic        out_Hazard1;
  logic        out_Hazard2;
  logic [7:0]  out_ConflictCnt;

  modport master (
    output in_Hold, in_ValidA, in_AddrA, in_DataA, in_ValidB, in_AddrB, in_DataB,
           in_ReadReg1, in_ReadReg2,
    input  out_ReadyA, out_ReadyB, out_RegWrite, out_WriteAddr, out_Data,
           out_Hazard1, out_Hazard2, out_ConflictCnt
  );

  modport slave (
    input  in_Hold, in_ValidA, in_AddrA, in_DataA, in_ValidB, in_AddrB, in_DataB,
           in_ReadReg1, in_ReadReg2,
    output out_ReadyA, out_ReadyB, out_RegWrite, out_WriteAddr, out_Data,
           out_Hazard1, out_Hazard2, out_ConflictCnt
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging ALU (A) and load (B) writebacks into one register-file write port,
// with read-hazard flags and a saturating conflict counter.
module regfile_write_arbiter (
  input logic                     CLK,
  input logic                     RST,
  regfile_write_arbiter_if.slave  bus
);
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} gnt_e;

  gnt_e              last_gnt_q, last_gnt_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic grant_a_c, grant_b_c, both_valid_c, active_c;

  // Grant decision: ties go to whichever requester was not granted last.
  always_comb begin
    active_c     = !RST && !bus.in_Hold;
    both_valid_c = bus.in_ValidA && bus.in_ValidB;
    grant_a_c    = active_c && bus.in_ValidA && (!bus.in_ValidB || (last_gnt_q == GNT_B));
    grant_b_c    = active_c && bus.in_ValidB && (!bus.in_ValidA || (last_gnt_q == GNT_A));
  end

  always_comb begin
    last_gnt_d     = last_gnt_q;
    reg_write_d    = 1'b0;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;
    conflict_cnt_d = conflict_cnt_q;
    if (RST) begin
      last_gnt_d     = GNT_B;
      write_addr_d   = '0;
      write_data_d   = '0;
      conflict_cnt_d = '0;
    end else begin
      if (grant_a_c) begin
        last_gnt_d   = GNT_A;
        write_addr_d = bus.in_AddrA;
        write_data_d = bus.in_DataA;
        reg_write_d  = (bus.in_AddrA != ADDR_W'(0));
      end else if (grant_b_c) begin
        last_gnt_d   = GNT_B;
        write_addr_d = bus.in_AddrB;
        write_data_d = bus.in_DataB;
        reg_write_d  = (bus.in_AddrB != ADDR_W'(0));
      end
      if (active_c && both_valid_c && (conflict_cnt_q != CNT_MAX)) begin
        conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    last_gnt_q     <= last_gnt_d;
    reg_write_q    <= reg_write_d;
    write_addr_q   <= write_addr_d;
    write_data_q   <= write_data_d;
    conflict_cnt_q <= conflict_cnt_d;
  end

  // Writes to register 0 never set reg_write_q, so hazards on address 0 cannot fire.
  assign bus.out_ReadyA      = grant_a_c;
  assign bus.out_ReadyB      = grant_b_c;
  assign bus.out_RegWrite    = reg_write_q;
  assign bus.out_WriteAddr   = write_addr_q;
  assign bus.out_Data        = write_data_q;
  assign bus.out_ConflictCnt = conflict_cnt_q;
  assign bus.out_Hazard1     = reg_write_q && (bus.in_ReadReg1 == write_addr_q);
  assign bus.out_Hazard2     = reg_write_q && (bus.in_ReadReg2 == write_addr_q);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Advance to 1ns after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_Hold     = 1'b0;
    bus.in_ValidA   = 1'b0;
    bus.in_AddrA    = 4'd0;
    bus.in_DataA    = 16'd0;
    bus.in_ValidB   = 1'b0;
    bus.in_AddrB    = 4'd0;
    bus.in_DataB    = 16'd0;
    bus.in_ReadReg1 = 4'd0;
    bus.in_ReadReg2 = 4'd0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    bus.in_ValidA = 1'b1;
    bus.in_AddrA  = 4'd9;
    bus.in_ValidB = 1'b1;
    bus.in_AddrB  = 4'd10;
    #1;
    checks++;
    if (bus.out_ReadyA !== 1'b0 || bus.out_ReadyB !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got A=%b B=%b want 0 0", bus.out_ReadyA, bus.out_ReadyB);
    end
    tick();
    #1;
    checks++;
    if (bus.out_RegWrite !== 1'b0 || bus.out_WriteAddr !== 4'd0 || bus.out_Data !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h want 0 0 0",
               bus.out_RegWrite, bus.out_WriteAddr, bus.out_Data);
    end
    checks++;
    if (bus.out_ConflictCnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", bus.out_ConflictCnt);
    end
    RST = 1'b0;
    clear_inputs();
  endtask

  task automatic test_a_only();
    do_reset();
    bus.in_ValidA = 1'b1;
    bus.in_AddrA  = 4'd3;
    bus.in_DataA  = 16'h0042;
    #1;
    checks++;
    if (bus.out_ReadyA !== 1'b1 || bus.out_ReadyB !== 1'b0) begin
      errors++;
      $display("FAIL a_only_ready: got A=%b B=%b want 1 0", bus.out_ReadyA, bus.out_ReadyB);
    end
    tick();
    bus.in_ValidA = 1'b0;
    bus.in_AddrA  = 4'd8;
    #1;
    checks++;
    if (bus.out_RegWrite !== 1'b1 || bus.out_WriteAddr !== 4'd3 || bus.out_Data !== 16'h0042) begin
      errors++;
      $display("FAIL a_only_write: got we=%b addr=%h data=%h want 1 3 0042",
               bus.out_RegWrite, bus.out_WriteAddr, bus.out_Data);
    end
    tick();
    #1;
    checks++;
    if (bus.out_RegWrite !== 1'b0 || bus.out_WriteAddr !== 4'd3 || bus.out_Data !== 16'h0042) begin
      errors++;
      $display("FAIL idle_hold: got we=%b addr=%h data=%h want 0 3 0042",
               bus.out_RegWrite, bus.out_WriteAddr, bus.out_Data);
    end
  endtask

  task automatic test_round_robin();
    logic exp_a;
    do_reset();
    bus.in_ValidA = 1'b1;
    bus.in_AddrA  = 4'd4;
    bus.in_DataA  = 16'h1111;
    bus.in_ValidB = 1'b1;
    bus.in_AddrB  = 4'd5;
    bus.in_DataB  = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      checks++;
      if (bus.out_ReadyA !== exp_a || bus.out_ReadyB !== !exp_a) begin
        errors++;
        $display("FAIL rr_grant%0d: got A=%b B=%b want %b %b",
                 i, bus.out_ReadyA, bus.out_ReadyB, exp_a, !exp_a);
      end
      if (i > 0) begin
        // Previous grant was the opposite of this cycle's.
        checks++;
        if (bus.out_RegWrite !== 1'b1 || bus.out_WriteAddr !== (exp_a ? 4'd5 : 4'd4) ||
            bus.out_Data !== (exp_a ? 16'h2222 : 16'h1111)) begin
          errors++;
          $display("FAIL rr_write%0d: got we=%b addr=%h data=%h",
                   i - 1, bus.out_RegWrite, bus.out_WriteAddr, bus.out_Data);
        end
      end
      tick();
    end
    clear_inputs();
    #1;
    checks++;
    if (bus.out_RegWrite !== 1'b1 || bus.out_WriteAddr !== 4'd5 || bus.out_Data !== 16'h2222) begin
      errors++;
      $display("FAIL rr_write3: got we=%b addr=%h data=%h want 1 5 2222",
               bus.out_RegWrite, bus.out_WriteAddr, bus.out_Data);
    end
    checks++;
    if (bus.out_ConflictCnt !== 8'd4) begin
      errors++;
      $display("FAIL rr_cnt: got %0d want 4", bus.out_ConflictCnt);
    end
  endtask

  task automatic test_addr_zero();
    do_reset();
    bus.in_ValidA = 1'b1;
    bus.in_AddrA  = 4'd0;
    bus.in_DataA  = 16'hFFFF;
    #1;
    checks++;
    if (bus.out_ReadyA !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready: got %b want 1", bus.out_ReadyA);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.out_RegWrite !== 1'b0 || bus.out_Hazard1 !== 1'b0 || bus.out_Hazard2 !== 1'b0 ||
        bus.out_Data !== 16'hFFFF) begin
      errors++;
      $display("FAIL zero_write: got we=%b hz1=%b hz2=%b data=%h want 0 0 0 ffff",
               bus.out_RegWrite, bus.out_Hazard1, bus.out_Hazard2, bus.out_Data);
    end
  endtask

  task automatic test_hazard();
    tick();
    bus.in_ValidB = 1'b1;
    bus.in_AddrB  = 4'd7;
    bus.in_DataB  = 16'h0777;
    #1;
    checks++;
    if (bus.out_ReadyB !== 1'b1 || bus.out_ReadyA !== 1'b0) begin
      errors++;
      $display("FAIL haz_ready: got A=%b B=%b want 0 1", bus.out_ReadyA, bus.out_ReadyB);
    end
    tick();
    bus.in_ValidB   = 1'b0;
    bus.in_ReadReg1 = 4'd7;
    bus.in_ReadReg2 = 4'd2;
    #1;
    checks++;
    if (bus.out_RegWrite !== 1'b1 || bus.out_Hazard1 !== 1'b1 || bus.out_Hazard2 !== 1'b0) begin
      errors++;
      $display("FAIL haz_active: got we=%b hz1=%b hz2=%b want 1 1 0",
               bus.out_RegWrite, bus.out_Hazard1, bus.out_Hazard2);
    end
    tick();
    #1;
    checks++;
    if (bus.out_Hazard1 !== 1'b0 || bus.out_Hazard2 !== 1'b0) begin
      errors++;
      $display("FAIL haz_idle: got hz1=%b hz2=%b want 0 0", bus.out_Hazard1, bus.out_Hazard2);
    end
    clear_inputs();
  endtask

  task automatic test_hold();
    do_reset();
    bus.in_ValidA = 1'b1;
    bus.in_AddrA  = 4'd1;
    bus.in_DataA  = 16'h0001;
    tick();
    // A was granted last, so B is favoured once the stall lifts.
    bus.in_Hold   = 1'b1;
    bus.in_ValidB = 1'b1;
    bus.in_AddrB  = 4'd2;
    bus.in_DataB  = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.out_ReadyA !== 1'b0 || bus.out_ReadyB !== 1'b0) begin
        errors++;
        $display("FAIL hold_ready%0d: got A=%b B=%b want 0 0", i, bus.out_ReadyA, bus.out_ReadyB);
      end
      if (i > 0) begin
        checks++;
        if (bus.out_RegWrite !== 1'b0) begin
          errors++;
          $display("FAIL hold_write%0d: got we=%b want 0", i, bus.out_RegWrite);
        end
      end
      tick();
    end
    #1;
    checks++;
    if (bus.out_RegWrite !== 1'b0 || bus.out_ConflictCnt !== 8'd0) begin
      errors++;
      $display("FAIL hold_state: got we=%b cnt=%0d want 0 0", bus.out_RegWrite, bus.out_ConflictCnt);
    end
    bus.in_Hold = 1'b0;
    #1;
    checks++;
    if (bus.out_ReadyA !== 1'b0 || bus.out_ReadyB !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got A=%b B=%b want 0 1", bus.out_ReadyA, bus.out_ReadyB);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.out_ConflictCnt !== 8'd1 || bus.out_WriteAddr !== 4'd2) begin
      errors++;
      $display("FAIL hold_after: got cnt=%0d addr=%h want 1 2", bus.out_ConflictCnt, bus.out_WriteAddr);
    end
  endtask

  task automatic test_same_addr();
    do_reset();
    bus.in_ValidA = 1'b1;
    bus.in_AddrA  = 4'd6;
    bus.in_DataA  = 16'hAAAA;
    bus.in_ValidB = 1'b1;
    bus.in_AddrB  = 4'd6;
    bus.in_DataB  = 16'hBBBB;
    tick();
    bus.in_DataA = 16'hCCCC;
    #1;
    checks++;
    if (bus.out_Data !== 16'hAAAA || bus.out_WriteAddr !== 4'd6 || bus.out_ReadyB !== 1'b1) begin
      errors++;
      $display("FAIL same_first: got data=%h addr=%h readyB=%b want aaaa 6 1",
               bus.out_Data, bus.out_WriteAddr, bus.out_ReadyB);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.out_RegWrite !== 1'b1 || bus.out_Data !== 16'hBBBB || bus.out_WriteAddr !== 4'd6) begin
      errors++;
      $display("FAIL same_final: got we=%b data=%h addr=%h want 1 bbbb 6",
               bus.out_RegWrite, bus.out_Data, bus.out_WriteAddr);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    bus.in_ValidA = 1'b1;
    bus.in_AddrA  = 4'd4;
    bus.in_DataA  = 16'h4444;
    bus.in_ValidB = 1'b1;
    bus.in_AddrB  = 4'd5;
    bus.in_DataB  = 16'h5555;
    for (int i = 0; i < 300; i++) tick();
    #1;
    checks++;
    if (bus.out_ConflictCnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_cnt: got %0d want 255", bus.out_ConflictCnt);
    end
    checks++;
    if (bus.out_RegWrite !== 1'b1) begin
      errors++;
      $display("FAIL sat_pending: got we=%b want 1", bus.out_RegWrite);
    end
    RST = 1'b1;
    tick();
    #1;
    checks++;
    if (bus.out_RegWrite !== 1'b0 || bus.out_WriteAddr !== 4'd0 || bus.out_Data !== 16'd0 ||
        bus.out_ConflictCnt !== 8'd0) begin
      errors++;
      $display("FAIL sat_reset: got we=%b addr=%h data=%h cnt=%0d want 0 0 0 0",
               bus.out_RegWrite, bus.out_WriteAddr, bus.out_Data, bus.out_ConflictCnt);
    end
    checks++;
    if (bus.out_ReadyA !== 1'b0 || bus.out_ReadyB !== 1'b0) begin
      errors++;
      $display("FAIL sat_rst_ready: got A=%b B=%b want 0 0", bus.out_ReadyA, bus.out_ReadyB);
    end
    RST = 1'b0;
    #1;
    checks++;
    if (bus.out_ReadyA !== 1'b1 || bus.out_ReadyB !== 1'b0) begin
      errors++;
      $display("FAIL sat_first_tie: got A=%b B=%b want 1 0", bus.out_ReadyA, bus.out_ReadyB);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.out_RegWrite !== 1'b1 || bus.out_WriteAddr !== 4'd4 || bus.out_ConflictCnt !== 8'd1) begin
      errors++;
      $display("FAIL sat_after: got we=%b addr=%h cnt=%0d want 1 4 1",
               bus.out_RegWrite, bus.out_WriteAddr, bus.out_ConflictCnt);
    end
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_a_only();
    test_round_robin();
    test_addr_zero();
    test_hazard();
    test_hold();
    test_same_addr();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL provide ports, clock and reset first:
 CLK  in  1  clock, all state updates on rising edge
 RST  in  1  reset, synchronous, active-high
 in_Hold  in  1  freeze grants (pipeline stall)
 in_ValidA  in  1  requester A (ALU writeback) has a write
 in_AddrA  in  4  A destination register
 in_DataA  in  16  A write data
 out_ReadyA  out  1  A accepted this cycle
 in_ValidB  in  1  requester B (memory load) has a write
 in_AddrB  in  4  B destination register
 in_DataB  in  16  B write data
 out_ReadyB  out  1  B accepted this cycle
 in_ReadReg1  in  4  register-file read address 1 (hazard compare)
 in_ReadReg2  in  4  register-file read address 2 (hazard compare)
 out_RegWrite  out  1  register-file write enable
 out_WriteAddr  out  4  register-file write address
 out_Data  out  16  register-file write data
 out_Hazard1  out  1  ReadReg1 matches write issuing this cycle
 out_Hazard2  out  1  ReadReg2 matches write issuing this cycle
 out_ConflictCnt  out  8  saturating count of both-valid cycles
REQ-002 SHALL use a single clock domain; no parameters.

Function
REQ-003 SHALL grant at most one requester per cycle; out_ReadyA/out_ReadyB combinational, never both high.
REQ-004 Only one valid, in_Hold=0: that requester SHALL be granted.
REQ-005 Both valid, in_Hold=0: SHALL grant the requester not granted most recently (round-robin bit LastGnt).
REQ-006 LastGnt SHALL update only on a grant, to the granted requester.
REQ-007 A requester held valid SHALL wait at most 1 cycle while the other stays valid.
REQ-008 in_Hold=1: SHALL deassert both Ready, grant nothing, leave LastGnt and counter unchanged.
REQ-009 A granted request SHALL be captured at the rising edge; out_RegWrite/out_WriteAddr/out_Data SHALL present it the next cycle (latency 1), for exactly one cycle.
REQ-010 Captured address 4'b0000 SHALL be accepted (Ready high) but produce out_RegWrite=0; out_WriteAddr/out_Data still load.
REQ-011 Cycle after no grant: out_RegWrite=0, out_WriteAddr/out_Data hold previous values.
REQ-012 Requester inputs SHALL be sampled only in the grant cycle; later changes do not affect a captured write.
REQ-013 Both valid with the same address: SHALL serialize per REQ-005; the later grant's write is final.
REQ-014 out_HazardN SHALL be 1 iff out_RegWrite=1 and in_ReadRegN == out_WriteAddr; combinational; never 1 for address 0.
REQ-015 out_ConflictCnt SHALL increment on each cycle with both valid and in_Hold=0; saturates at 255, no wrap.
REQ-016 Ready asserted only when matching Valid asserted.

Reset
REQ-017 RST=1 at a rising edge SHALL set out_RegWrite=0, out_WriteAddr=0, out_Data=0, out_ConflictCnt=0, LastGnt=B (A wins first tie).
REQ-018 While RST=1, out_ReadyA/out_ReadyB SHALL be 0; requests presented then are not accepted and not written.
REQ-019 RST asserted the cycle after a grant SHALL cancel that pending write (out_RegWrite=0 next cycle).
REQ-020 First grant possible in the first cycle with RST=0.

Verification
REQ-021 Reset, then A only: ValidA=1, AddrA=3, DataA=0x0042 -> ReadyA=1 same cycle; next cycle RegWrite=1, WriteAddr=3, Data=0x0042.
REQ-022 Both valid 4 cycles after reset (A addr 4, B addr 5) -> grants A,B,A,B; writes appear one cycle later in that order; ConflictCnt=4.
REQ-023 A only with AddrA=0, DataA=0xFFFF -> ReadyA=1; next cycle RegWrite=0, Hazard1=Hazard2=0 with ReadReg1=0.
REQ-024 B granted AddrB=7; next cycle ReadReg1=7, ReadReg2=2 -> Hazard1=1, Hazard2=0; following idle cycle both 0.
REQ-025 in_Hold=1 with both valid 3 cycles -> no Ready, RegWrite=0, ConflictCnt unchanged; release -> previously un-favoured requester granted first.
REQ-026 Both valid 300 cycles -> ConflictCnt=255; RST mid-run -> all outputs 0 next cycle, counter 0, A wins first tie after release.
